edge_checker: RTL

Synthesizable, multi-channel hardware counterpart of the SVA sampled-value checks ($rose/$fell/$stable/$changed), used as an on-chip/bench protocol monitor. Each channel samples a 1-bit signal on a strobe, compares it with its previous sample, and evaluates a per-channel runtime mode. It reports failures as pulses, saturating counters, sticky flags and a first-failure capture record.

---
 rtl/edge_chk_pkg.sv | 22 ++
 rtl/edge_chk_lane.sv | 50 +++++
 rtl/edge_checker.sv | 78 +++++++
 3 files changed

// File: rtl/edge_chk_pkg.sv
// rtl/edge_chk_pkg.sv - check modes and pass evaluation for the edge checker
package edge_chk_pkg;

  typedef enum logic [1:0] {
    CHK_RISE    = 2'd0,
    CHK_FELL    = 2'd1,
    CHK_STABLE  = 2'd2,
    CHK_CHANGED = 2'd3
  } chk_mode_e;

  function automatic logic chk_pass(input chk_mode_e mode, input logic prev, input logic cur);
    logic w_pass;
    case (mode)
      CHK_RISE:    w_pass = !prev && cur;
      CHK_FELL:    w_pass = prev && !cur;
      CHK_STABLE:  w_pass = (prev == cur);
      default:     w_pass = (prev != cur);
    endcase
    return w_pass;
  endfunction

endpackage

// File: rtl/edge_chk_lane.sv
// rtl/edge_chk_lane.sv - one monitored channel: history, pulse, sticky flag, saturating count
module edge_chk_lane
  import edge_chk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sample_en,
  input  logic             i_sig,
  input  logic [1:0]       i_mode,
  input  logic             i_chk_en,
  input  logic             i_clr,
  output logic             o_fail_now,
  output logic             o_fail_pulse,
  output logic             o_fail_sticky,
  output logic [CNT_W-1:0] o_fail_cnt
);

  logic             r_prev;
  logic             r_pulse;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  assign o_fail_now    = i_sample_en && i_chk_en && !chk_pass(chk_mode_e'(i_mode), r_prev, i_sig);
  assign o_fail_pulse  = r_pulse;
  assign o_fail_sticky = r_sticky;
  assign o_fail_cnt    = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev   <= 1'b0;
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // History advances on every sample, even when the result is masked or cleared
      if (i_sample_en) r_prev <= i_sig;
      r_pulse <= o_fail_now && !i_clr;
      if (i_clr) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end else if (o_fail_now) begin
        r_sticky <= 1'b1;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/edge_checker.sv
// rtl/edge_checker.sv - multi-channel sampled-value checker with first-failure capture
module edge_checker
  import edge_chk_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic [N_CH-1:0]       sig_in,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       chk_en,
  input  logic                  clr,
  output logic [N_CH-1:0]       fail_pulse,
  output logic [N_CH-1:0]       fail_sticky,
  output logic [CNT_W*N_CH-1:0] fail_cnt,
  output logic [TS_W-1:0]       sample_cnt,
  output logic                  first_fail_vld,
  output logic [CH_W-1:0]       first_fail_ch,
  output logic [TS_W-1:0]       first_fail_ts
);

  logic [N_CH-1:0] w_fail;
  logic [CH_W-1:0] w_fail_idx;
  logic [TS_W-1:0] r_sample_cnt;
  logic            r_ff_vld;
  logic [CH_W-1:0] r_ff_ch;
  logic [TS_W-1:0] r_ff_ts;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    edge_chk_lane #(.CNT_W(CNT_W)) u_lane (
      .clk           (clk),
      .rst           (rst),
      .i_sample_en   (sample_en),
      .i_sig         (sig_in[g]),
      .i_mode        (mode[2*g +: 2]),
      .i_chk_en      (chk_en[g]),
      .i_clr         (clr),
      .o_fail_now    (w_fail[g]),
      .o_fail_pulse  (fail_pulse[g]),
      .o_fail_sticky (fail_sticky[g]),
      .o_fail_cnt    (fail_cnt[CNT_W*g +: CNT_W])
    );
  end

  // Scan downward so the lowest failing channel is the one left standing
  always_comb begin
    w_fail_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_fail[i]) w_fail_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sample_cnt <= '0;
      r_ff_vld     <= 1'b0;
      r_ff_ch      <= '0;
      r_ff_ts      <= '0;
    end else begin
      if (sample_en) r_sample_cnt <= r_sample_cnt + TS_W'(1);
      if (!r_ff_vld && (|w_fail)) begin
        r_ff_vld <= 1'b1;
        r_ff_ch  <= w_fail_idx;
        r_ff_ts  <= r_sample_cnt;
      end
    end
  end

  assign sample_cnt     = r_sample_cnt;
  assign first_fail_vld = r_ff_vld;
  assign first_fail_ch  = r_ff_ch;
  assign first_fail_ts  = r_ff_ts;

endmodule
